// File: rtl/max7219_sink.sv
// rtl/max7219_sink.sv - receive-side MAX7219 daisy-chain model with register images
// Optional DOUT chain output modelled when MAX7219_SINK_DOUT_EN is defined.
module max7219_sink #(
  parameter int DEVICES = 2,
  parameter int CNT_W   = 8
) (
  input  logic                   CLK_66,
  input  logic                   reset,
  input  logic                   spi_clk,
  input  logic                   spi_din,
  input  logic                   spi_load,
  output logic [DEVICES*64-1:0]  digits,
  output logic [DEVICES*8-1:0]   decode_mode,
  output logic [DEVICES*4-1:0]   intensity,
  output logic [DEVICES*3-1:0]   scan_limit,
  output logic [DEVICES-1:0]     shutdown_n,
  output logic [DEVICES-1:0]     display_test,
  output logic                   load_strobe,
  output logic                   frame_error,
  output logic                   spi_dout
);

  localparam int FW = 16 * DEVICES;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FW);

  // [0]/[1] are the synchroniser stages, [2] holds the previous synced value
  logic [2:0]       clk_p, din_p, load_p;
  logic [FW-1:0]    shreg;
  logic [CNT_W-1:0] bit_cnt;

  logic clk_rise, load_rise, load_fall, shift_en;
  assign clk_rise  = clk_p[1] & ~clk_p[2];
  assign load_rise = load_p[1] & ~load_p[2];
  assign load_fall = ~load_p[1] & load_p[2];
  // A clock rise coinciding with a LOAD rise sees load_p[1]=1 and is dropped
  assign shift_en  = clk_rise & ~load_p[1];

  always_ff @(posedge CLK_66) begin
    if (reset) begin
      clk_p        <= 3'b000;
      din_p        <= 3'b000;
      load_p       <= 3'b111;
      shreg        <= '0;
      bit_cnt      <= '0;
      digits       <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= '0;
      display_test <= '0;
      load_strobe  <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      clk_p       <= {clk_p[1:0], spi_clk};
      din_p       <= {din_p[1:0], spi_din};
      load_p      <= {load_p[1:0], spi_load};
      load_strobe <= 1'b0;

      if (shift_en)
        shreg <= {shreg[FW-2:0], din_p[1]};

      if (load_fall)
        bit_cnt <= shift_en ? CNT_W'(1) : '0;
      else if (shift_en && bit_cnt != '1)
        bit_cnt <= bit_cnt + CNT_W'(1);

      if (load_rise) begin
        if (bit_cnt == FRAME_LEN) begin
          load_strobe <= 1'b1;
          // Device 0 sits nearest the driver, so it owns the last 16 bits shifted
          for (int d = 0; d < DEVICES; d++) begin
            case (shreg[16*d+8 +: 4])
              4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
                digits[d*64 + (int'(shreg[16*d+8 +: 4]) - 1)*8 +: 8] <= shreg[16*d +: 8];
              4'h9: decode_mode[d*8 +: 8]  <= shreg[16*d +: 8];
              4'hA: intensity[d*4 +: 4]    <= shreg[16*d +: 4];
              4'hB: scan_limit[d*3 +: 3]   <= shreg[16*d +: 3];
              4'hC: shutdown_n[d]          <= shreg[16*d];
              4'hF: display_test[d]        <= shreg[16*d];
              default: ;
            endcase
          end
        end else begin
          frame_error <= 1'b1;
        end
      end
    end
  end

`ifdef MAX7219_SINK_DOUT_EN
  logic clk_fall;
  assign clk_fall = ~clk_p[1] & clk_p[2];

  always_ff @(posedge CLK_66) begin
    if (reset)
      spi_dout <= 1'b0;
    else if (clk_fall)
      spi_dout <= shreg[FW-1];
  end
`else
  assign spi_dout = 1'b0;
`endif

endmodule

// File: tb/tb_max7219_sink.sv
// tb/tb_max7219_sink.sv - scoreboard bench for max7219_sink with a register-level reference model
`timescale 1ns/1ps
module tb_max7219_sink;
  localparam int HP = 6;

  logic         CLK_66 = 1'b0;
  logic         reset, spi_clk, spi_din, spi_load;
  logic [127:0] digits;
  logic [15:0]  decode_mode;
  logic [7:0]   intensity;
  logic [5:0]   scan_limit;
  logic [1:0]   shutdown_n, display_test;
  logic         load_strobe, frame_error, spi_dout;

  max7219_sink #(.DEVICES(2), .CNT_W(8)) dut (
    .CLK_66(CLK_66), .reset(reset), .spi_clk(spi_clk), .spi_din(spi_din), .spi_load(spi_load),
    .digits(digits), .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
    .shutdown_n(shutdown_n), .display_test(display_test), .load_strobe(load_strobe),
    .frame_error(frame_error), .spi_dout(spi_dout)
  );

  always #7.5 CLK_66 = ~CLK_66;

  typedef struct packed {
    logic [127:0] dg;
    logic [15:0]  dm;
    logic [7:0]   it;
    logic [5:0]   sl;
    logic [1:0]   sd;
    logic [1:0]   dt;
  } img_t;

  int   tests = 0, fails = 0;
  img_t exp_q[$];

  // Reference model: per-device register arrays
  logic [7:0] m_dig [2][8];
  logic [7:0] m_dm [2];
  logic [3:0] m_it [2];
  logic [2:0] m_sl [2];
  logic       m_sd [2];
  logic       m_dt [2];
  bit         m_ferr;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 8; n++) m_dig[d][n] = 8'h00;
      m_dm[d] = 0; m_it[d] = 0; m_sl[d] = 0; m_sd[d] = 0; m_dt[d] = 0;
    end
    m_ferr = 0;
  endtask

  task automatic model_apply(input logic [31:0] f);
    for (int d = 0; d < 2; d++) begin
      int addr;
      logic [7:0] data;
      addr = int'(f[16*d+8 +: 4]);
      data = f[16*d +: 8];
      if (addr >= 1 && addr <= 8) m_dig[d][addr-1] = data;
      else if (addr == 9)  m_dm[d] = data;
      else if (addr == 10) m_it[d] = data[3:0];
      else if (addr == 11) m_sl[d] = data[2:0];
      else if (addr == 12) m_sd[d] = data[0];
      else if (addr == 15) m_dt[d] = data[0];
    end
  endtask

  function automatic img_t model_image();
    img_t r;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 8; n++) r.dg[d*64 + n*8 +: 8] = m_dig[d][n];
      r.dm[d*8 +: 8] = m_dm[d];
      r.it[d*4 +: 4] = m_it[d];
      r.sl[d*3 +: 3] = m_sl[d];
      r.sd[d] = m_sd[d];
      r.dt[d] = m_dt[d];
    end
    return r;
  endfunction

  function automatic img_t dut_image();
    return {digits, decode_mode, intensity, scan_limit, shutdown_n, display_test};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: every strobe cycle must match the next queued register image
  always @(negedge CLK_66) begin
    if (!reset && load_strobe) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got strobe, expected none");
      end else begin
        img_t e, g;
        e = exp_q.pop_front();
        g = dut_image();
        if (g !== e) begin
          fails++;
          $display("FAIL latch_image: got dg=%h dm=%h it=%h sl=%h sd=%b dt=%b, expected dg=%h dm=%h it=%h sl=%h sd=%b dt=%b",
                   g.dg, g.dm, g.it, g.sl, g.sd, g.dt, e.dg, e.dm, e.it, e.sl, e.sd, e.dt);
        end
      end
    end
  end

  task automatic clk_bit(input logic b, input bit chk, input logic expb);
    spi_din = b;
    repeat (HP) @(posedge CLK_66);
    #1;
    if (chk) check("dout_bit", {127'b0, spi_dout}, {127'b0, expb});
    spi_clk = 1'b1;
    repeat (HP) @(posedge CLK_66);
    #1;
    spi_clk = 1'b0;
  endtask

  // Shift the low n bits MSB-first, then raise LOAD (optionally together with one extra clock rise)
  task automatic send(input logic [63:0] bits, input int n, input bit sim, input bit chk, input logic [31:0] prev);
    spi_load = 1'b0;
    repeat (HP) @(posedge CLK_66);
    for (int i = n - 1; i >= 0; i--) begin
      int j;
      j = n - 1 - i;
      clk_bit(bits[i], chk && j < 32, prev[(31 - j) & 31]);
    end
    if (sim) begin
      spi_din = $urandom_range(0, 1);
      repeat (HP) @(posedge CLK_66);
      #1;
      spi_clk  = 1'b1;
      spi_load = 1'b1;
      repeat (2*HP) @(posedge CLK_66);
      #1;
      spi_clk = 1'b0;
    end else begin
      repeat (HP) @(posedge CLK_66);
      #1;
      spi_load = 1'b1;
    end
    repeat (2*HP) @(posedge CLK_66);
  endtask

  task automatic frame(input logic [63:0] bits, input int n, input bit sim, input bit chk, input logic [31:0] prev);
    if (n == 32) begin
      model_apply(bits[31:0]);
      exp_q.push_back(model_image());
    end else begin
      m_ferr = 1;
    end
    send(bits, n, sim, chk, prev);
    @(negedge CLK_66);
    check("strobe_seen", {96'b0, 32'(exp_q.size())}, 128'd0);
    exp_q.delete();
    check("frame_error", {127'b0, frame_error}, {127'b0, m_ferr});
    check("image_hold", dut_image(), model_image());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    spi_clk = 1'b0;
    spi_load = 1'b1;
    spi_din = 1'b0;
    repeat (5) @(posedge CLK_66);
    model_reset();
    @(negedge CLK_66);
    check("reset_image", dut_image(), 128'd0);
    check("reset_flags", {125'b0, load_strobe, frame_error, spi_dout}, 128'd0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] fa, fb;
    spi_din = 1'b0;
    do_reset();

    frame(64'h0C01_0B07, 32, 0, 0, 0);
    check("scan_limit_dev0", {125'b0, scan_limit[2:0]}, 128'd7);
    check("shutdown_n", {126'b0, shutdown_n}, 128'b10);

    frame(64'h0000_015A, 32, 0, 0, 0);
    check("digit0_dev0", {120'b0, digits[7:0]}, 128'h5A);
    check("digits_dev1", {64'b0, digits[127:64]}, 128'd0);
    frame(64'h0000_08A5, 32, 0, 0, 0);
    check("digit7_dev0", {120'b0, digits[63:56]}, 128'hA5);

    frame(64'h000F_FFFF, 20, 0, 0, 0);
    frame(64'h0901_0933, 32, 0, 0, 0);
    check("error_sticky", {127'b0, frame_error}, 128'd1);
    do_reset();

    spi_load = 1'b0;
    repeat (HP) @(posedge CLK_66);
    for (int i = 0; i < 17; i++) clk_bit(1'b1, 0, 1'b0);
    do_reset();
    frame(64'h0F01_0A0F, 32, 0, 0, 0);
    check("intensity_dev0", {124'b0, intensity[3:0]}, 128'hF);
    check("display_test", {126'b0, display_test}, 128'b10);

    frame(64'h0C01_0C01, 32, 1, 0, 0);

    fa = $urandom;
    fb = $urandom;
    frame({32'b0, fa}, 32, 0, 0, 0);
`ifdef MAX7219_SINK_DOUT_EN
    frame({32'b0, fb}, 32, 0, 1, fa);
`else
    frame({32'b0, fb}, 32, 0, 0, 0);
    check("dout_tied", {127'b0, spi_dout}, 128'd0);
`endif

    for (int k = 0; k < 30; k++) begin
      logic [63:0] r;
      int n;
      r = {$urandom, $urandom};
      n = 32;
      if ($urandom_range(0, 9) < 2) begin
        n = $urandom_range(0, 40);
        if (n == 32) n = 31;
      end
      frame(r, n, n == 32 && $urandom_range(0, 3) == 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
